// File: rtl/queue_pkg.sv
// Shared constants and types for the consumer side of the 4-entry special queue.
// Any block that drives or watches that queue imports these.
package queue_pkg;

    localparam int DW = 6;

    // One-hot read selects; SEL0 addresses the queue head.
    localparam logic [3:0] SEL0 = 4'b0001;
    localparam logic [3:0] SEL1 = 4'b0010;
    localparam logic [3:0] SEL2 = 4'b0100;
    localparam logic [3:0] SEL3 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SEND,
        SETTLE
    } drain_state_t;

endpackage

// File: rtl/drain_out_reg.sv
// Holding register for one stream beat (valid/data/last).
// The beat is loaded from the queue and held until the consumer accepts it.
module drain_out_reg
    import queue_pkg::*;
#(
    parameter int W = DW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last
);

    // NOTE: flops use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (clear) begin
            // Data is left in place; only the qualifiers drop after acceptance.
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/queue_drain.sv
// Consumer-side controller that pops a commanded burst from the special queue
// onto a valid/ready stream, and offers a non-destructive peek while idle.
module queue_drain
    import queue_pkg::drain_state_t, queue_pkg::IDLE, queue_pkg::CHECK,
           queue_pkg::SEND, queue_pkg::SETTLE, queue_pkg::SEL0;
#(
    parameter int         DW       = queue_pkg::DW,
    parameter logic [3:0] HEAD_SEL = SEL0,
    parameter int         TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    count,
    input  logic          peek_req,
    input  logic [3:0]    peek_sel,
    input  logic          q_empty,
    input  logic [DW-1:0] q_data,
    output logic          q_pop,
    output logic [3:0]    q_rd_sel,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          peek_valid,
    output logic [DW-1:0] peek_data,
    output logic          busy,
    output logic          done,
    output logic          timeout_err
);

    localparam int            WW         = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT);

    drain_state_t  state, state_next;
    logic [2:0]    remaining, remaining_next;
    logic [WW-1:0] wait_cnt, wait_next, wait_inc;
    logic          done_next, timeout_next;
    logic          peek_load;
    logic          out_load, out_clear;

    // Saturating so the counter can never roll over while the queue stays empty.
    assign wait_inc = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;
    assign busy     = (state != IDLE);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        wait_next      = wait_cnt;
        done_next      = 1'b0;
        timeout_next   = 1'b0;
        peek_load      = 1'b0;
        out_load       = 1'b0;
        out_clear      = 1'b0;
        q_pop          = 1'b0;
        q_rd_sel       = HEAD_SEL;

        // Reset holds the queue interface quiet so no entry is popped during it.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != 3'd0) begin
                            remaining_next = count;
                            wait_next      = '0;
                            state_next     = CHECK;
                        end
                    end else if (peek_req) begin
                        q_rd_sel  = peek_sel;
                        peek_load = 1'b1;
                    end
                end

                CHECK: begin
                    if (!q_empty) begin
                        q_pop      = 1'b1;
                        out_load   = 1'b1;
                        state_next = SEND;
                    end else begin
                        wait_next = wait_inc;
                        if (wait_inc == WAIT_LIMIT) begin
                            done_next    = 1'b1;
                            timeout_next = 1'b1;
                            state_next   = IDLE;
                        end
                    end
                end

                SEND: begin
                    if (m_ready) begin
                        out_clear      = 1'b1;
                        remaining_next = remaining - 3'd1;
                        // Treating anything at or below one as final keeps remaining from wrapping.
                        if (remaining <= 3'd1) begin
                            remaining_next = 3'd0;
                            done_next      = 1'b1;
                            state_next     = IDLE;
                        end else begin
                            state_next = SETTLE;
                        end
                    end
                end

                SETTLE: begin
                    // Dead cycle: the queue's registered empty flag catches up with the last pop.
                    wait_next  = '0;
                    state_next = CHECK;
                end

                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= 3'd0;
            wait_cnt    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            peek_valid  <= 1'b0;
            peek_data   <= '0;
        end else begin
            state       <= state_next;
            remaining   <= remaining_next;
            wait_cnt    <= wait_next;
            done        <= done_next;
            timeout_err <= timeout_next;
            peek_valid  <= peek_load;
            if (peek_load) begin
                peek_data <= q_data;
            end
        end
    end

    drain_out_reg #(
        .W(DW)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (out_load),
        .clear    (out_clear),
        .load_data(q_data),
        .load_last(remaining == 3'd1),
        .valid    (m_valid),
        .data     (m_data),
        .last     (m_last)
    );

endmodule

// File: doc/queue_drain.md
Name: queue_drain

Overview:
- Consumer-side controller for the 4-entry, 6-bit special queue.
- Drives the queue's pop and one-hot rd_sel inputs and watches its empty flag and data_out.
- Pops a commanded burst of 1..7 entries and delivers each entry on a valid/ready stream.
- In IDLE it also offers a non-destructive peek of any entry through rd_sel.

Parameters:
- DW, 6, data width; matches the queue data path.
- HEAD_SEL, 4'b0001, one-hot rd_sel value that addresses the queue head.
- TIMEOUT, 15, maximum cycles to wait on q_empty in CHECK before aborting a burst (1..255).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  burst request; sampled only in IDLE
- count  in  3  burst length; 0 is ignored
- peek_req  in  1  peek request; sampled only in IDLE when start=0
- peek_sel  in  4  one-hot entry to peek
- q_empty  in  1  queue empty flag
- q_data  in  DW  queue data_out; combinational function of q_rd_sel
- q_pop  out  1  queue pop strobe
- q_rd_sel  out  4  queue read select
- m_valid  out  1  stream data valid
- m_data  out  DW  stream data
- m_last  out  1  marks the final beat of a burst
- m_ready  in  1  downstream ready
- peek_valid  out  1  one-cycle pulse; peek_data is valid
- peek_data  out  DW  registered peek result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a burst ends
- timeout_err  out  1  one-cycle pulse, coincident with done, when a burst aborts

Behaviour:
- Reset (sync, active-high) dominates every state:
  - state=IDLE
  - all registered outputs 0: m_valid, m_data, m_last, peek_valid, peek_data, done, timeout_err
  - remaining counter and wait counter cleared
  - q_pop=0, q_rd_sel=HEAD_SEL
- Reset mid-burst abandons the burst. No done pulse; entries already popped are lost.
- States: IDLE, CHECK, SEND, SETTLE.
- IDLE:
  - start=1 and count!=0: latch remaining=count, clear wait counter, go to CHECK.
  - start=1 and count=0: stay in IDLE, no activity.
  - peek_req=1 (start=0): q_rd_sel=peek_sel combinationally in that cycle. q_data is registered into peek_data at the edge and peek_valid pulses the next cycle. No pop.
  - start has priority over peek_req.
  - Otherwise q_rd_sel=HEAD_SEL.
- CHECK:
  - q_rd_sel=HEAD_SEL.
  - If q_empty=0: q_pop=1 combinationally for this cycle only, q_data is captured into m_data, m_last=(remaining==1), go to SEND.
  - If q_empty=1: increment the wait counter. When it reaches TIMEOUT, pulse done and timeout_err, go to IDLE. No pop is issued that cycle.
- SEND:
  - m_valid=1 and m_data/m_last are held stable until m_ready=1.
  - Handshake cycle: decrement remaining, drop m_valid at the edge.
  - If the decremented value is 0: pulse done the next cycle and go to IDLE.
  - Otherwise go to SETTLE.
- SETTLE: one dead cycle so the queue's registered empty flag reflects the previous pop. Clear the wait counter, go to CHECK.
- Latency:
  - start at edge N puts the FSM in CHECK during cycle N+1 (pop there if non-empty).
  - m_valid is asserted from cycle N+2.
  - Steady-state throughput is one entry per 3 cycles with m_ready held at 1.
- q_pop is never asserted outside CHECK and never on two consecutive cycles, so the queue is never popped while empty.
- start and peek_req are ignored while busy=1.
- remaining is 3 bits and never wraps; reaching 0 always ends the burst.
- The wait counter is sized for TIMEOUT and saturates; it is cleared on every entry to CHECK from IDLE or SETTLE.

Decomposition:
- Shared package queue_pkg:
  - DW constant
  - one-hot select constants SEL0..SEL3 (HEAD_SEL default = SEL0)
  - state enum drain_state_t {IDLE, CHECK, SEND, SETTLE}
- Natural sub-module: drain_out_reg, the m_valid/m_data/m_last holding register with load/clear controls.
- FSM and counters stay in queue_drain.

Test Plan:
- Queue preloaded with 0x11,0x22,0x33; start, count=3; m_ready=1:
  - three beats 0x11,0x22,0x33 on m_data, m_last only on 0x33
  - exactly 3 q_pop pulses, each separated by ≥2 cycles
  - done pulses once, timeout_err=0
- Queue holds 1 entry 0x05; count=2; TIMEOUT=4:
  - beat 0x05 with m_last=0
  - then q_empty stays 1 for 4 cycles in CHECK
  - done and timeout_err pulse together, busy falls, only 1 q_pop seen
- Backpressure, one entry 0x2A, count=1; m_ready=0 for 5 cycles then 1:
  - m_valid stays high with m_data=0x2A held for 6 cycles
  - single q_pop, done one cycle after the handshake
- Peek in IDLE, peek_req=1, peek_sel=4'b0100:
  - q_rd_sel=4'b0100 in that cycle
  - peek_valid pulses with peek_data equal to the queue's entry 2
  - q_pop stays 0 and the queue occupancy is unchanged
- start with count=0 ->
  - busy stays 0
  - no q_pop, no done
- Mid-burst rst=1 for one cycle while in SEND ->
  - next cycle state=IDLE, all outputs 0, q_rd_sel=HEAD_SEL, no done pulse
  - a subsequent start behaves normally
